// File: rtl/fa_cell.sv
// One-bit full adder cell: the leaf of the ripple chain inside full_adder.
`timescale 1ns/1ps
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  // The propagate term is shared between the sum and the carry.
  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder built from fa_cell.
// The combinational sum/cout come with a registered, valid-qualified copy.
`timescale 1ns/1ps
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             out_valid
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  // Reset outranks in_valid, so a capture requested during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      cout_q    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum;
        cout_q <= cout;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Directed bench for full_adder at WIDTH=1 and WIDTH=4.
`timescale 1ns/1ps
module tb_full_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       a1, b1, cin1, iv1;
  logic       s1, c1, sq1, cq1, ov1;

  logic [3:0] a4, b4, s4, sq4;
  logic       cin4, iv4, c4, cq4, ov4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(s1), .cout(c1), .sum_q(sq1), .cout_q(cq1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .in_valid(iv4),
    .sum(s4), .cout(c4), .sum_q(sq4), .cout_q(cq4), .out_valid(ov4)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {cout,sum} indexed by {a,b,cin}.
  logic [1:0] exp_tab [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    logic [2:0] v;
    logic [1:0] e;
    rst = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a4 = 0; b4 = 0; cin4 = 0; iv4 = 0;

    @(posedge clk); #1;
    check("rst_sum_q1",  {7'd0, sq1}, 8'h00);
    check("rst_ov1",     {7'd0, ov1}, 8'h00);
    check("rst_sum_q4",  {4'd0, sq4}, 8'h00);
    check("rst_cout_q4", {7'd0, cq4}, 8'h00);
    check("rst_ov4",     {7'd0, ov4}, 8'h00);

    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {a1, b1, cin1} = v;
      #1;
      check($sformatf("exh_%0d", i), {6'd0, c1, s1}, {6'd0, exp_tab[i]});
    end

    // rst stays high: combinational path must still follow the inputs
    for (int i = 0; i < 10; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      #1;
      e = {1'b0, a1} + {1'b0, b1} + {1'b0, cin1};
      check($sformatf("rnd_%0d", i), {6'd0, c1, s1}, {6'd0, e});
    end

    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1; #1;
    check("ripple_full", {3'd0, c4, s4}, 8'h10);
    a4 = 4'h7; b4 = 4'h8; cin4 = 1'b0; #1;
    check("ripple_7p8",  {3'd0, c4, s4}, 8'h0F);
    a4 = 4'hA; b4 = 4'h6; cin4 = 1'b1; #1;
    check("ripple_a6c",  {3'd0, c4, s4}, 8'h11);

    @(negedge clk);
    rst = 1'b0; a4 = 4'h3; b4 = 4'h5; cin4 = 1'b1; iv4 = 1'b1;
    @(posedge clk); #1;
    check("reg_sum_q",  {4'd0, sq4}, 8'h09);
    check("reg_cout_q", {7'd0, cq4}, 8'h00);
    check("reg_ov",     {7'd0, ov4}, 8'h01);

    @(negedge clk);
    iv4 = 1'b0; a4 = 4'hC; b4 = 4'h7; cin4 = 1'b0;
    @(posedge clk); #1;
    check("hold_sum_q",  {4'd0, sq4}, 8'h09);
    check("hold_cout_q", {7'd0, cq4}, 8'h00);
    check("hold_ov",     {7'd0, ov4}, 8'h00);

    @(negedge clk);
    iv4 = 1'b1; a4 = 4'hE; b4 = 4'h3; cin4 = 1'b0;
    @(posedge clk); #1;
    check("load_sum_q",  {4'd0, sq4}, 8'h01);
    check("load_cout_q", {7'd0, cq4}, 8'h01);

    @(negedge clk);
    rst = 1'b1; iv4 = 1'b1; a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    #1;
    check("rst_comb", {3'd0, c4, s4}, 8'h1F);
    @(posedge clk); #1;
    check("midrst_sum_q",  {4'd0, sq4}, 8'h00);
    check("midrst_cout_q", {7'd0, cq4}, 8'h00);
    check("midrst_ov",     {7'd0, ov4}, 8'h00);

    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0; #1;
    check("all_zero", {3'd0, c4, s4}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
